// File: rtl/retired_store_buffer.sv
// Post-retirement store buffer.
// Retired stores from up to N_WAY ROB lanes are compacted into a circular
// FIFO. A small drain FSM presents the head entry to data memory with
// registered req/addr/data/size and pops it on mem_ack. The buffer also
// gives the ROB back-pressure (sb_ready) and the load unit a word-granular
// address-conflict check (ld_conflict). Retired stores are architectural,
// so nothing in here ever flushes an entry other than the memory drain.
module retired_store_buffer #(
  parameter int N_WAY    = 2,
  parameter int XLEN     = 32,
  parameter int SB_DEPTH = 8
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [N_WAY-1:0]              ret_st_valid,
  input  logic [N_WAY*XLEN-1:0]         ret_st_addr,
  input  logic [N_WAY*XLEN-1:0]         ret_st_data,
  input  logic [N_WAY*2-1:0]            ret_st_size,
  output logic                          sb_ready,
  output logic                          mem_req,
  output logic [XLEN-1:0]               mem_addr,
  output logic [XLEN-1:0]               mem_data,
  output logic [1:0]                    mem_size,
  input  logic                          mem_ack,
  input  logic [XLEN-1:0]               ld_addr,
  output logic                          ld_conflict,
  output logic [$clog2(SB_DEPTH):0]     sb_count,
  output logic                          sb_empty,
  output logic                          sb_overflow
);

  localparam int PW = $clog2(SB_DEPTH);
  localparam int CW = PW + 1;

  localparam logic [CW-1:0] C_DEPTH = CW'(SB_DEPTH);
  localparam logic [CW-1:0] C_NWAY  = CW'(N_WAY);
  localparam logic [CW-1:0] C_ZERO  = {CW{1'b0}};
  localparam logic [CW-1:0] C_ONE   = {{PW{1'b0}}, 1'b1};
  localparam logic [PW-1:0] P_ONE   = {{(PW-1){1'b0}}, 1'b1};

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  // Number of asserted lane valids; the buffer is deeper than N_WAY so
  // the result always fits in a count-width value.
  function automatic logic [CW-1:0] f_popcount(input logic [N_WAY-1:0] vec);
    logic [CW-1:0] cnt;
    cnt = {CW{1'b0}};
    for (int i = 0; i < N_WAY; i++) begin
      cnt = cnt + {{PW{1'b0}}, vec[i]};
    end
    return cnt;
  endfunction

  // Entry storage
  logic [XLEN-1:0]      r_ent_addr [SB_DEPTH];
  logic [XLEN-1:0]      r_ent_data [SB_DEPTH];
  logic [1:0]           r_ent_size [SB_DEPTH];
  logic [SB_DEPTH-1:0]  r_ent_valid;

  // Queue bookkeeping
  logic [PW-1:0]        r_head;
  logic [PW-1:0]        r_tail;
  logic [CW-1:0]        r_count;
  logic                 r_overflow;

  // Drain FSM and registered memory interface
  state_t               r_state;
  state_t               w_state_nxt;
  logic                 r_mem_req;
  logic [XLEN-1:0]      r_mem_addr;
  logic [XLEN-1:0]      r_mem_data;
  logic [1:0]           r_mem_size;

  // Enqueue datapath
  logic [CW-1:0]        w_free;
  logic [CW-1:0]        w_req_cnt;
  logic [CW-1:0]        w_slot;
  logic [PW-1:0]        w_slot_idx;
  logic [SB_DEPTH-1:0]  w_wr_en;
  logic [XLEN-1:0]      w_wr_addr [SB_DEPTH];
  logic [XLEN-1:0]      w_wr_data [SB_DEPTH];
  logic [1:0]           w_wr_size [SB_DEPTH];
  logic [CW-1:0]        w_enq_n;
  logic                 w_enq_over;

  // Drain control
  logic                 w_deq;
  logic                 w_load;
  logic [PW-1:0]        w_load_idx;
  logic                 w_req_nxt;

  // Load conflict
  logic                 w_conflict;
  logic                 w_unused_ld_low;

  // The byte offset of the load address never matters: the check is per word.
  assign w_unused_ld_low = ^ld_addr[1:0];

  assign w_free     = C_DEPTH - r_count;
  assign w_req_cnt  = f_popcount(ret_st_valid);
  assign w_enq_n    = w_slot;
  assign w_enq_over = (w_req_cnt > w_free);
  assign w_deq      = (r_state == ST_BUSY) && mem_ack;

  // Compact valid lanes into consecutive free slots starting at tail; lanes beyond the free space are dropped.
  always_comb begin
    w_wr_en    = {SB_DEPTH{1'b0}};
    w_slot     = {CW{1'b0}};
    w_slot_idx = {PW{1'b0}};
    for (int k = 0; k < SB_DEPTH; k++) begin
      w_wr_addr[k] = {XLEN{1'b0}};
      w_wr_data[k] = {XLEN{1'b0}};
      w_wr_size[k] = 2'b00;
    end
    for (int i = 0; i < N_WAY; i++) begin
      if (ret_st_valid[i] && (w_slot < w_free)) begin
        w_slot_idx            = r_tail + w_slot[PW-1:0];
        w_wr_en[w_slot_idx]   = 1'b1;
        w_wr_addr[w_slot_idx] = ret_st_addr[i*XLEN +: XLEN];
        w_wr_data[w_slot_idx] = ret_st_data[i*XLEN +: XLEN];
        w_wr_size[w_slot_idx] = ret_st_size[i*2 +: 2];
        w_slot                = w_slot + C_ONE;
      end else begin
        w_slot = w_slot;
      end
    end
  end

  // Entry array: write newly retired stores, clear the valid bit of a popped head.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_ent_valid <= {SB_DEPTH{1'b0}};
      for (int k = 0; k < SB_DEPTH; k++) begin
        r_ent_addr[k] <= {XLEN{1'b0}};
        r_ent_data[k] <= {XLEN{1'b0}};
        r_ent_size[k] <= 2'b00;
      end
    end else begin
      for (int k = 0; k < SB_DEPTH; k++) begin
        if (w_wr_en[k]) begin
          r_ent_addr[k]  <= w_wr_addr[k];
          r_ent_data[k]  <= w_wr_data[k];
          r_ent_size[k]  <= w_wr_size[k];
          r_ent_valid[k] <= 1'b1;
        end else if (w_deq && (r_head == PW'(k))) begin
          r_ent_valid[k] <= 1'b0;
        end
      end
    end
  end

  // Head/tail/count pointers and the sticky overflow flag.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_head     <= {PW{1'b0}};
      r_tail     <= {PW{1'b0}};
      r_count    <= {CW{1'b0}};
      r_overflow <= 1'b0;
    end else begin
      if (w_deq) begin
        r_head <= r_head + P_ONE;
      end
      r_tail  <= r_tail + w_enq_n[PW-1:0];
      r_count <= r_count + w_enq_n - {{PW{1'b0}}, w_deq};
      if (w_enq_over) begin
        r_overflow <= 1'b1;
      end
    end
  end

  // Drain FSM state register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Drain FSM next state: stay busy while acked entries keep following each other.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (r_count != C_ZERO) begin
          w_state_nxt = ST_BUSY;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (mem_ack && (r_count <= C_ONE)) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_BUSY;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Drain FSM outputs: decide the next request level and which entry (if any) to load into the payload.
  always_comb begin
    w_load     = 1'b0;
    w_load_idx = r_head;
    w_req_nxt  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (r_count != C_ZERO) begin
          w_load     = 1'b1;
          w_load_idx = r_head;
          w_req_nxt  = 1'b1;
        end else begin
          w_req_nxt  = 1'b0;
        end
      end
      ST_BUSY: begin
        if (mem_ack) begin
          if (r_count > C_ONE) begin
            w_load     = 1'b1;
            w_load_idx = r_head + P_ONE;
            w_req_nxt  = 1'b1;
          end else begin
            w_req_nxt  = 1'b0;
          end
        end else begin
          w_req_nxt = 1'b1;
        end
      end
      default: begin
        w_req_nxt = 1'b0;
      end
    endcase
  end

  // Registered memory request and payload; payload holds steady until the next load.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_mem_req  <= 1'b0;
      r_mem_addr <= {XLEN{1'b0}};
      r_mem_data <= {XLEN{1'b0}};
      r_mem_size <= 2'b00;
    end else begin
      r_mem_req <= w_req_nxt;
      if (w_load) begin
        r_mem_addr <= r_ent_addr[w_load_idx];
        r_mem_data <= r_ent_data[w_load_idx];
        r_mem_size <= r_ent_size[w_load_idx];
      end
    end
  end

  // Word-granular overlap of the load address against every buffered store, including the one in flight.
  always_comb begin
    w_conflict = 1'b0;
    for (int k = 0; k < SB_DEPTH; k++) begin
      if (r_ent_valid[k] && (r_ent_addr[k][XLEN-1:2] == ld_addr[XLEN-1:2])) begin
        w_conflict = 1'b1;
      end else begin
        w_conflict = w_conflict;
      end
    end
  end

  assign sb_ready    = (w_free >= C_NWAY);
  assign mem_req     = r_mem_req;
  assign mem_addr    = r_mem_addr;
  assign mem_data    = r_mem_data;
  assign mem_size    = r_mem_size;
  assign ld_conflict = w_conflict;
  assign sb_count    = r_count;
  assign sb_empty    = (r_count == C_ZERO);
  assign sb_overflow = r_overflow;

endmodule

// File: tb/tb_retired_store_buffer.sv
// Bench for retired_store_buffer: a queue-based reference model plus
// directed scenarios with literal expectations and a randomized phase.
module tb_retired_store_buffer;

  localparam int N_WAY    = 2;
  localparam int XLEN     = 32;
  localparam int SB_DEPTH = 8;
  localparam int CW       = $clog2(SB_DEPTH) + 1;

  logic                  clock = 1'b0;
  logic                  reset = 1'b0;
  logic [N_WAY-1:0]      ret_st_valid = '0;
  logic [N_WAY*XLEN-1:0] ret_st_addr  = '0;
  logic [N_WAY*XLEN-1:0] ret_st_data  = '0;
  logic [N_WAY*2-1:0]    ret_st_size  = '0;
  logic                  sb_ready;
  logic                  mem_req;
  logic [XLEN-1:0]       mem_addr;
  logic [XLEN-1:0]       mem_data;
  logic [1:0]            mem_size;
  logic                  mem_ack = 1'b0;
  logic [XLEN-1:0]       ld_addr = '0;
  logic                  ld_conflict;
  logic [CW-1:0]         sb_count;
  logic                  sb_empty;
  logic                  sb_overflow;

  retired_store_buffer #(.N_WAY(N_WAY), .XLEN(XLEN), .SB_DEPTH(SB_DEPTH)) dut (
    .clock(clock), .reset(reset),
    .ret_st_valid(ret_st_valid), .ret_st_addr(ret_st_addr),
    .ret_st_data(ret_st_data), .ret_st_size(ret_st_size),
    .sb_ready(sb_ready), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_data(mem_data), .mem_size(mem_size), .mem_ack(mem_ack),
    .ld_addr(ld_addr), .ld_conflict(ld_conflict), .sb_count(sb_count),
    .sb_empty(sb_empty), .sb_overflow(sb_overflow)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  size;
  } st_t;

  st_t mq[$];       // stores held by the buffer, oldest first
  bit  m_req = 1'b0;
  bit  m_ovf = 1'b0;
  int  m_free;
  st_t m_e;

  function automatic bit m_conflict(input logic [31:0] a);
    foreach (mq[i]) begin
      if (mq[i].addr[31:2] == a[31:2]) return 1'b1;
    end
    return 1'b0;
  endfunction

  // Model: a request is outstanding after an edge exactly when the buffer held
  // something that was not popped at that edge (this edge's retires excluded).
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      mq.delete();
      m_req = 1'b0;
      m_ovf = 1'b0;
    end else begin
      m_free = SB_DEPTH - mq.size();
      if (m_req && mem_ack) void'(mq.pop_front());
      m_req = (mq.size() != 0);
      for (int i = 0; i < N_WAY; i++) begin
        if (ret_st_valid[i]) begin
          if (m_free > 0) begin
            m_e.addr = ret_st_addr[i*XLEN +: XLEN];
            m_e.data = ret_st_data[i*XLEN +: XLEN];
            m_e.size = ret_st_size[i*2 +: 2];
            mq.push_back(m_e);
            m_free--;
          end else begin
            m_ovf = 1'b1;
          end
        end
      end
    end
  end

  // Compare every cycle on the falling edge.
  always @(negedge clock) begin
    chk("sb_count", 64'(sb_count), 64'(mq.size()));
    chk("sb_empty", 64'(sb_empty), 64'(mq.size() == 0));
    chk("sb_ready", 64'(sb_ready), 64'((SB_DEPTH - mq.size()) >= N_WAY));
    chk("mem_req", 64'(mem_req), 64'(m_req));
    chk("sb_overflow", 64'(sb_overflow), 64'(m_ovf));
    chk("ld_conflict", 64'(ld_conflict), 64'(m_conflict(ld_addr)));
    if (m_req && mq.size() != 0) begin
      chk("mem_addr", 64'(mem_addr), 64'(mq[0].addr));
      chk("mem_data", 64'(mem_data), 64'(mq[0].data));
      chk("mem_size", 64'(mem_size), 64'(mq[0].size));
    end
  end

  // Record every store memory accepts.
  logic [31:0] acc_q[$];
  always @(posedge clock) begin
    if (!reset && mem_req && mem_ack) acc_q.push_back(mem_addr);
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_lane(input int lane, input logic [31:0] a, input logic [31:0] d,
                          input logic [1:0] s);
    ret_st_valid[lane]            = 1'b1;
    ret_st_addr[lane*XLEN +: XLEN] = a;
    ret_st_data[lane*XLEN +: XLEN] = d;
    ret_st_size[lane*2 +: 2]      = s;
  endtask

  task automatic step();
    tick();
    ret_st_valid = '0;
  endtask

  task automatic pulse_reset();
    #1 reset = 1'b1;
    @(posedge clock);
    #3 reset = 1'b0;
    tick();
  endtask

  initial begin
    // Reset and idle
    #1 reset = 1'b1;
    @(posedge clock);
    #3 reset = 1'b0;
    repeat (2) tick();
    chk("rst_count", 64'(sb_count), 64'd0);
    chk("rst_empty", 64'(sb_empty), 64'd1);
    chk("rst_ready", 64'(sb_ready), 64'd1);
    chk("rst_req", 64'(mem_req), 64'd0);
    chk("rst_addr", 64'(mem_addr), 64'd0);
    chk("rst_ovf", 64'(sb_overflow), 64'd0);

    // Two stores in one cycle with ack held high
    mem_ack = 1'b1;
    set_lane(0, 32'h100, 32'hAA, 2'd2);
    set_lane(1, 32'h104, 32'hBB, 2'd2);
    step();
    chk("dual_count", 64'(sb_count), 64'd2);
    chk("dual_req0", 64'(mem_req), 64'd0);
    tick();
    chk("dual_req1", 64'(mem_req), 64'd1);
    chk("dual_addr1", 64'(mem_addr), 64'h100);
    chk("dual_data1", 64'(mem_data), 64'hAA);
    tick();
    chk("dual_addr2", 64'(mem_addr), 64'h104);
    chk("dual_data2", 64'(mem_data), 64'hBB);
    chk("dual_count2", 64'(sb_count), 64'd1);
    tick();
    chk("dual_req_end", 64'(mem_req), 64'd0);
    chk("dual_empty", 64'(sb_empty), 64'd1);

    // Stalled memory: payload holds steady
    mem_ack = 1'b0;
    set_lane(0, 32'h300, 32'h12345678, 2'd1);
    step();
    tick();
    repeat (5) begin
      chk("stall_req", 64'(mem_req), 64'd1);
      chk("stall_addr", 64'(mem_addr), 64'h300);
      chk("stall_data", 64'(mem_data), 64'h12345678);
      chk("stall_size", 64'(mem_size), 64'd1);
      tick();
    end
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk("stall_pop_req", 64'(mem_req), 64'd0);
    chk("stall_pop_count", 64'(sb_count), 64'd0);

    // Reset in the middle of a request
    set_lane(0, 32'h310, 32'h55, 2'd0);
    step();
    tick();
    chk("busy_req", 64'(mem_req), 64'd1);
    #2 reset = 1'b1;
    #1;
    chk("async_req", 64'(mem_req), 64'd0);
    chk("async_count", 64'(sb_count), 64'd0);
    @(posedge clock);
    #3 reset = 1'b0;
    mem_ack = 1'b1;
    tick();
    tick();
    chk("idle_ack_req", 64'(mem_req), 64'd0);
    mem_ack = 1'b0;

    // Fill, then overflow
    for (int k = 0; k < 8; k++) begin
      chk("fill_ready", 64'(sb_ready), 64'(k <= 6));
      set_lane(0, 32'h500 + 32'(4 * k), 32'(k), 2'd2);
      step();
    end
    chk("full_count", 64'(sb_count), 64'd8);
    chk("full_ready", 64'(sb_ready), 64'd0);
    set_lane(0, 32'h600, 32'hFF, 2'd2);
    step();
    chk("ovf_flag", 64'(sb_overflow), 64'd1);
    chk("ovf_count", 64'(sb_count), 64'd8);
    repeat (3) tick();
    chk("ovf_sticky", 64'(sb_overflow), 64'd1);
    acc_q.delete();
    mem_ack = 1'b1;
    repeat (10) tick();
    mem_ack = 1'b0;
    chk("ovf_drain_n", 64'(acc_q.size()), 64'd8);
    for (int k = 0; k < 8 && k < acc_q.size(); k++)
      chk("ovf_drain_addr", 64'(acc_q[k]), 64'h500 + 64'(4 * k));
    chk("ovf_after_drain", 64'(sb_overflow), 64'd1);
    pulse_reset();
    chk("ovf_cleared", 64'(sb_overflow), 64'd0);

    // Wrap: lane-1-only retires with continuous ack
    acc_q.delete();
    mem_ack = 1'b1;
    for (int k = 0; k < 12; k++) begin
      set_lane(1, 32'h400 + 32'(4 * k), 32'hC000 + 32'(k), 2'd2);
      step();
    end
    repeat (6) tick();
    chk("wrap_n", 64'(acc_q.size()), 64'd12);
    for (int k = 0; k < 12 && k < acc_q.size(); k++)
      chk("wrap_addr", 64'(acc_q[k]), 64'h400 + 64'(4 * k));
    chk("wrap_empty", 64'(sb_empty), 64'd1);
    mem_ack = 1'b0;

    // Load conflict
    set_lane(0, 32'h200, 32'hDEAD, 2'd2);
    step();
    ld_addr = 32'h202;
    #1 chk("ldc_hit", 64'(ld_conflict), 64'd1);
    ld_addr = 32'h204;
    #1 chk("ldc_miss", 64'(ld_conflict), 64'd0);
    set_lane(0, 32'h208, 32'h1, 2'd2);
    ld_addr = 32'h208;
    #1 chk("ldc_same_cycle", 64'(ld_conflict), 64'd0);
    step();
    #1 chk("ldc_next_cycle", 64'(ld_conflict), 64'd1);
    mem_ack = 1'b1;
    repeat (4) tick();
    mem_ack = 1'b0;
    ld_addr = 32'h202;
    #1 chk("ldc_after_pop", 64'(ld_conflict), 64'd0);
    tick();

    // Randomized traffic
    for (int c = 0; c < 400; c++) begin
      mem_ack = ($urandom_range(0, 3) != 0);
      ld_addr = 32'h800 + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3));
      for (int i = 0; i < N_WAY; i++) begin
        if ($urandom_range(0, 1) == 1 && (sb_ready || c >= 300))
          set_lane(i, 32'h800 + 32'(4 * $urandom_range(0, 15)), $urandom, 2'($urandom_range(0, 2)));
      end
      step();
    end
    mem_ack = 1'b1;
    repeat (20) tick();
    chk("rand_drained", 64'(sb_empty), 64'd1);
    mem_ack = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
